hit_fsm: RTL and testbench
==========================

Name: hit_fsm

Overview:
- Receiving end of the attack protocol: consumes opponent attack contacts (type encoded as the attack FSM's 3-bit attack type) and drives this fighter's damage, hitstun, knockback and invulnerability.
- Its hit_stun_active output feeds back into the fighter's own attack FSM to cancel attacks.
- One instance per fighter, clocked on the system clock; all game-time behaviour advances on frame_tick.

Parameters:
- BASE_STUN, 8: minimum hitstun frames.
- MAX_STUN, 40: hitstun cap in frames.
- BASE_KB, 4: base knockback magnitude.
- KB_MAX, 120: knockback magnitude cap (must be ≤127).
- INVULN_FRAMES, 30: post-stun invulnerability frames.
- PCT_MAX, 999: damage percent saturation value.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- hit_valid  in  1  contact pulse from collision logic; any cycle
- hit_type  in  3  1 neutral, 2 side, 3 up, 4 down; 0 and 5-7 invalid
- hit_from_left  in  1  1 = attacker left of this fighter (push toward +x)
- hit_stun_active  out  1  high in HITSTUN
- invuln  out  1  high in INVULN
- anim_state  out  4  10 in HITSTUN, 0 otherwise
- damage_pct  out  10  accumulated damage, unsigned
- knock_pulse  out  1  one clk, marks a knockback vector
- knock_vx  out  8  signed, valid with knock_pulse
- knock_vy  out  8  signed, +y down, valid with knock_pulse

Behaviour:
- Reset (async):
  - state IDLE, timers 0, latch empty, damage_pct 0.
  - All outputs 0; knock_vx/vy = 0.
- Hit latch:
  - hit_valid with a valid hit_type, seen in any clk while the latch is empty, captures {type, from_left}.
  - First capture wins; later contacts are dropped until the latch is consumed.
  - Invalid types are never captured.
- Latch consumption: on a frame_tick with the latch full, the latch clears.
  - In IDLE: the hit is applied.
  - In HITSTUN/INVULN: the hit is discarded.
  - A hit_valid in the same clk as that frame_tick is not captured.
- Apply hit (in the frame_tick clk):
  - Damage by type: neutral 3, side 5, up 4, down 6.
  - new_pct = min(damage_pct + dmg, PCT_MAX).
  - stun = min(BASE_STUN + (new_pct>>4), MAX_STUN).
  - mag = min(BASE_KB + (new_pct>>3), KB_MAX).
  - s = +1 if from_left, else -1.
  - Knockback vector by type:
    - neutral: vx = s*(mag>>1), vy = -(mag>>2).
    - side: vx = s*mag, vy = -(mag>>1).
    - up: vx = 0, vy = -mag.
    - down: vx = s*(mag>>2), vy = +(mag>>1).
  - Registered outputs update on the next clk edge: damage_pct = new_pct, timer = stun, state HITSTUN, knock_pulse = 1 for exactly one clk.
- HITSTUN:
  - Each frame_tick decrements the timer.
  - A tick seen with timer == 1 moves to INVULN with timer = INVULN_FRAMES.
  - hit_stun_active is therefore high for exactly stun frame_ticks.
- INVULN:
  - Same countdown; a tick seen with timer == 1 returns to IDLE.
  - If INVULN_FRAMES = 0, go straight to IDLE.
- knock_vx/vy hold their last value between pulses.
- Intermediate arithmetic is ≥11 bits wide so it cannot wrap before saturation.
- No frame_tick means no state or timer change; the latch still captures.
- Reset mid-stun or mid-invuln returns to the reset values immediately.

Optional Feature:
- Macro: HIT_SHIELD_EN.
- When defined:
  - Adds input btn_shield (1 bit).
  - If btn_shield is high in IDLE at the apply tick: dmg is halved (floor), damage_pct is updated, and no stun or invuln is entered.
  - knock_pulse still fires, with vx = s*(mag>>2) and vy = 0.
- When undefined:
  - Port absent; every applied hit follows normal behaviour.

Test Plan:
- Neutral hit, pct 0, from_left=1 -> pct 3, knock_pulse one clk with vx=+2, vy=-1; hit_stun_active for 8 ticks; invuln for 30 ticks; then IDLE, anim_state 0.
- Side hit, pct 100, from_left=0 -> pct 105, stun 14 ticks, vx=-17, vy=-8.
- Down hit, pct 997 -> pct 999 (saturated), mag 120 (capped) so vx=+30 or -30 per from_left and vy=+60; stun 40 (capped).
- Two contacts before one tick, then a contact during HITSTUN and during INVULN -> only the first is applied; pct rises once; no knock_pulse for the later contacts.
- hit_type 0 and 7 pulses -> ignored; reset asserted mid-HITSTUN -> all outputs 0 the same cycle, pct 0.
- HIT_SHIELD_EN defined, btn_shield=1, side hit at pct 0 -> pct 2, hit_stun_active stays 0, vx=+1 or -1 per from_left, vy=0.

Source files
------------

// File: rtl/hit_fsm.sv
// -----------------------------------------------------------------------------
// hit_fsm -- receiving end of the attack protocol for one fighter.
//
// Catches opponent attack contacts in a one-deep latch. On the next frame tick
// the latched hit is applied if the fighter is idle, and discarded otherwise.
// Applying a hit adds damage, starts hitstun and emits a one-clock knockback
// vector. Hitstun is followed by invulnerability and then a return to idle.
// Game time advances only on frame_tick.
//
// Optional feature: define HIT_SHIELD_EN to add the btn_shield input. A hit
// that lands while shielding does half damage (floor) and a reduced,
// horizontal-only knockback, and it does not enter hitstun.
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   frame_tick      one-cycle pulse per video frame
//   hit_valid       contact pulse from collision logic, any cycle
//   hit_type        1 neutral, 2 side, 3 up, 4 down; other codes ignored
//   hit_from_left   1 = attacker is on the left (push toward +x)
//   btn_shield      (HIT_SHIELD_EN only) shield held
//   hit_stun_active high in HITSTUN, cancels this fighter's own attacks
//   invuln          high in INVULN
//   anim_state      10 in HITSTUN, 0 otherwise
//   damage_pct      accumulated damage, saturates at PCT_MAX
//   knock_pulse     one clock, marks a new knockback vector
//   knock_vx        signed x knockback, holds between pulses
//   knock_vy        signed y knockback (+y is down), holds between pulses
//   dbg_state       current FSM state (0 idle, 1 hitstun, 2 invuln)
//
// Handshake: hit_valid is a fire-and-forget pulse with no ready. A contact is
// taken only when the latch is empty and hit_type is valid; all others drop.
// knock_pulse is a one-clock valid with no back-pressure; knock_vx/vy are
// meaningful in that clock.
// -----------------------------------------------------------------------------
module hit_fsm #(
  parameter int BASE_STUN     = 8,
  parameter int MAX_STUN      = 40,
  parameter int BASE_KB       = 4,
  parameter int KB_MAX        = 120,
  parameter int INVULN_FRAMES = 30,
  parameter int PCT_MAX       = 999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       hit_valid,
  input  logic [2:0] hit_type,
  input  logic       hit_from_left,
`ifdef HIT_SHIELD_EN
  input  logic       btn_shield,
`endif
  output logic       hit_stun_active,
  output logic       invuln,
  output logic [3:0] anim_state,
  output logic [9:0] damage_pct,
  output logic       knock_pulse,
  output logic [7:0] knock_vx,
  output logic [7:0] knock_vy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HITSTUN = 2'd1,
    S_INVULN  = 2'd2
  } state_t;

  // Saturation bounds at the 11-bit working width so sums cannot wrap.
  localparam logic [10:0] L_PCT_MAX  = 11'(PCT_MAX);
  localparam logic [10:0] L_BASE_STN = 11'(BASE_STUN);
  localparam logic [10:0] L_MAX_STUN = 11'(MAX_STUN);
  localparam logic [10:0] L_BASE_KB  = 11'(BASE_KB);
  localparam logic [10:0] L_KB_MAX   = 11'(KB_MAX);
  localparam logic [7:0]  L_INVULN   = 8'(INVULN_FRAMES);

  state_t     r_state, w_state_n;
  logic [7:0] r_timer, w_timer_n;
  logic [9:0] r_pct, w_pct_n;
  logic       r_latch_full, w_latch_full_n;
  logic [2:0] r_latch_type, w_latch_type_n;
  logic       r_latch_left, w_latch_left_n;
  logic       r_knock_pulse, w_knock_pulse_n;
  logic [7:0] r_vx, w_vx_n;
  logic [7:0] r_vy, w_vy_n;

  logic        w_type_ok;
  logic        w_shield;
  logic        w_apply;
  logic [2:0]  w_dmg_base;
  logic [2:0]  w_dmg;
  logic [10:0] w_sum;
  logic [9:0]  w_new_pct;
  logic [10:0] w_stun_raw;
  logic [7:0]  w_stun;
  logic [10:0] w_mag_raw;
  logic [7:0]  w_mag;
  logic [7:0]  w_hx;
  logic [7:0]  w_hit_vx;
  logic [7:0]  w_hit_vy;

`ifdef HIT_SHIELD_EN
  assign w_shield = btn_shield;
`else
  assign w_shield = 1'b0;
`endif

  assign w_type_ok = (hit_type >= 3'd1) && (hit_type <= 3'd4);

  // Latch: first valid contact wins while empty; any tick with it full
  // consumes it, and a contact in that same clock is not taken.
  always_comb begin
    w_latch_full_n = r_latch_full;
    w_latch_type_n = r_latch_type;
    w_latch_left_n = r_latch_left;
    if (r_latch_full) begin
      if (frame_tick) begin
        w_latch_full_n = 1'b0;
      end
    end else if (hit_valid && w_type_ok) begin
      w_latch_full_n = 1'b1;
      w_latch_type_n = hit_type;
      w_latch_left_n = hit_from_left;
    end
  end

  assign w_apply = frame_tick && r_latch_full && (r_state == S_IDLE);

  // Hit arithmetic from the latched contact.
  always_comb begin
    case (r_latch_type)
      3'd1:    w_dmg_base = 3'd3;
      3'd2:    w_dmg_base = 3'd5;
      3'd3:    w_dmg_base = 3'd4;
      3'd4:    w_dmg_base = 3'd6;
      default: w_dmg_base = 3'd0;
    endcase
  end

  assign w_dmg      = w_shield ? (w_dmg_base >> 1) : w_dmg_base;
  assign w_sum      = {1'b0, r_pct} + {8'd0, w_dmg};
  assign w_new_pct  = (w_sum > L_PCT_MAX) ? L_PCT_MAX[9:0] : w_sum[9:0];
  assign w_stun_raw = L_BASE_STN + 11'(w_new_pct >> 4);
  assign w_stun     = (w_stun_raw > L_MAX_STUN) ? L_MAX_STUN[7:0] : w_stun_raw[7:0];
  assign w_mag_raw  = L_BASE_KB + 11'(w_new_pct >> 3);
  assign w_mag      = (w_mag_raw > L_KB_MAX) ? L_KB_MAX[7:0] : w_mag_raw[7:0];

  // w_hx is the unsigned horizontal magnitude; the side of the attacker
  // supplies the sign afterwards.
  always_comb begin
    w_hx     = 8'd0;
    w_hit_vy = 8'd0;
    if (w_shield) begin
      w_hx     = w_mag >> 2;
      w_hit_vy = 8'd0;
    end else begin
      case (r_latch_type)
        3'd1: begin
          w_hx     = w_mag >> 1;
          w_hit_vy = 8'd0 - (w_mag >> 2);
        end
        3'd2: begin
          w_hx     = w_mag;
          w_hit_vy = 8'd0 - (w_mag >> 1);
        end
        3'd3: begin
          w_hx     = 8'd0;
          w_hit_vy = 8'd0 - w_mag;
        end
        3'd4: begin
          w_hx     = w_mag >> 2;
          w_hit_vy = w_mag >> 1;
        end
        default: begin
          w_hx     = 8'd0;
          w_hit_vy = 8'd0;
        end
      endcase
    end
  end

  assign w_hit_vx = r_latch_left ? w_hx : (8'd0 - w_hx);

  // Next-state / output logic.
  always_comb begin
    w_state_n       = r_state;
    w_timer_n       = r_timer;
    w_pct_n         = r_pct;
    w_knock_pulse_n = 1'b0;
    w_vx_n          = r_vx;
    w_vy_n          = r_vy;
    case (r_state)
      S_IDLE: begin
        if (w_apply) begin
          w_pct_n         = w_new_pct;
          w_knock_pulse_n = 1'b1;
          w_vx_n          = w_hit_vx;
          w_vy_n          = w_hit_vy;
          if (!w_shield) begin
            w_state_n = S_HITSTUN;
            w_timer_n = w_stun;
          end
        end
      end
      S_HITSTUN: begin
        if (frame_tick) begin
          // <= 1 also covers a zero stun so the state can never stick.
          if (r_timer <= 8'd1) begin
            if (L_INVULN == 8'd0) begin
              w_state_n = S_IDLE;
              w_timer_n = 8'd0;
            end else begin
              w_state_n = S_INVULN;
              w_timer_n = L_INVULN;
            end
          end else begin
            w_timer_n = r_timer - 8'd1;
          end
        end
      end
      S_INVULN: begin
        if (frame_tick) begin
          if (r_timer <= 8'd1) begin
            w_state_n = S_IDLE;
            w_timer_n = 8'd0;
          end else begin
            w_timer_n = r_timer - 8'd1;
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_timer_n = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_timer       <= 8'd0;
      r_pct         <= 10'd0;
      r_latch_full  <= 1'b0;
      r_latch_type  <= 3'd0;
      r_latch_left  <= 1'b0;
      r_knock_pulse <= 1'b0;
      r_vx          <= 8'd0;
      r_vy          <= 8'd0;
    end else begin
      r_state       <= w_state_n;
      r_timer       <= w_timer_n;
      r_pct         <= w_pct_n;
      r_latch_full  <= w_latch_full_n;
      r_latch_type  <= w_latch_type_n;
      r_latch_left  <= w_latch_left_n;
      r_knock_pulse <= w_knock_pulse_n;
      r_vx          <= w_vx_n;
      r_vy          <= w_vy_n;
    end
  end

  assign hit_stun_active = (r_state == S_HITSTUN);
  assign invuln          = (r_state == S_INVULN);
  assign anim_state      = (r_state == S_HITSTUN) ? 4'd10 : 4'd0;
  assign damage_pct      = r_pct;
  assign knock_pulse     = r_knock_pulse;
  assign knock_vx        = r_vx;
  assign knock_vy        = r_vy;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_hit_fsm.sv
module tb_hit_fsm;

  localparam int BASE_STUN     = 8;
  localparam int MAX_STUN      = 40;
  localparam int BASE_KB       = 4;
  localparam int KB_MAX        = 120;
  localparam int INVULN_FRAMES = 30;
  localparam int PCT_MAX       = 999;
`ifdef HIT_SHIELD_EN
  localparam bit SHIELD_BUILD = 1'b1;
`else
  localparam bit SHIELD_BUILD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       hit_valid = 1'b0;
  logic [2:0] hit_type = 3'd0;
  logic       hit_from_left = 1'b0;
  logic       btn_shield = 1'b0;
  logic       hit_stun_active;
  logic       invuln;
  logic [3:0] anim_state;
  logic [9:0] damage_pct;
  logic       knock_pulse;
  logic [7:0] knock_vx;
  logic [7:0] knock_vy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  hit_fsm #(
    .BASE_STUN(BASE_STUN), .MAX_STUN(MAX_STUN), .BASE_KB(BASE_KB),
    .KB_MAX(KB_MAX), .INVULN_FRAMES(INVULN_FRAMES), .PCT_MAX(PCT_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .hit_valid(hit_valid),
    .hit_type(hit_type),
    .hit_from_left(hit_from_left),
`ifdef HIT_SHIELD_EN
    .btn_shield(btn_shield),
`endif
    .hit_stun_active(hit_stun_active),
    .invuln(invuln),
    .anim_state(anim_state),
    .damage_pct(damage_pct),
    .knock_pulse(knock_pulse),
    .knock_vx(knock_vx),
    .knock_vy(knock_vy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];   // expected {vx, vy} per knockback pulse

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Game-level view: frames of stun / invulnerability left, a pending hit,
  // and the last knockback vector.
  int m_pct, m_stun_left, m_inv_left, m_vx, m_vy;
  bit m_pending, m_pend_left, m_kp;
  int m_pend_type;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_pct = 0; m_stun_left = 0; m_inv_left = 0; m_vx = 0; m_vy = 0;
    m_pending = 0; m_pend_left = 0; m_pend_type = 0; m_kp = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit t, input bit hv, input int ht,
                            input bit hl, input bit sh);
    bit was_idle;
    bit shielded;
    int dmg, mag, s, hx, vy;
    m_kp = 0;
    was_idle = (m_stun_left == 0) && (m_inv_left == 0);
    if (t) begin
      if (m_stun_left > 0) begin
        m_stun_left--;
        if (m_stun_left == 0) m_inv_left = INVULN_FRAMES;
      end else if (m_inv_left > 0) begin
        m_inv_left--;
      end
    end
    if (t && m_pending && was_idle) begin
      shielded = SHIELD_BUILD && sh;
      dmg = (m_pend_type == 1) ? 3 : (m_pend_type == 2) ? 5 :
            (m_pend_type == 3) ? 4 : 6;
      if (shielded) dmg = dmg / 2;
      m_pct = imin(m_pct + dmg, PCT_MAX);
      mag = imin(BASE_KB + m_pct / 8, KB_MAX);
      s = m_pend_left ? 1 : -1;
      if (shielded) begin
        hx = mag / 4; vy = 0;
      end else begin
        case (m_pend_type)
          1: begin hx = mag / 2; vy = -(mag / 4); end
          2: begin hx = mag;     vy = -(mag / 2); end
          3: begin hx = 0;       vy = -mag;       end
          default: begin hx = mag / 4; vy = mag / 2; end
        endcase
        m_stun_left = imin(BASE_STUN + m_pct / 16, MAX_STUN);
      end
      m_vx = s * hx;
      m_vy = vy;
      m_kp = 1;
      exp_q.push_back({8'(m_vx), 8'(m_vy)});
    end
    if (m_pending) begin
      if (t) m_pending = 0;
    end else if (hv && ht >= 1 && ht <= 4) begin
      m_pending = 1; m_pend_type = ht; m_pend_left = hl;
    end
  endtask

  task automatic compare_all();
    logic [15:0] e;
    check("stun_active", int'(hit_stun_active), int'(m_stun_left > 0));
    check("invuln", int'(invuln), int'(m_stun_left == 0 && m_inv_left > 0));
    check("anim_state", int'(anim_state), (m_stun_left > 0) ? 10 : 0);
    check("damage_pct", int'(damage_pct), m_pct);
    check("knock_pulse", int'(knock_pulse), int'(m_kp));
    if (knock_pulse && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pulse_vx", int'($signed(knock_vx)), int'($signed(e[15:8])));
      check("pulse_vy", int'($signed(knock_vy)), int'($signed(e[7:0])));
    end
    check("hold_vx", int'($signed(knock_vx)), m_vx);
    check("hold_vy", int'($signed(knock_vy)), m_vy);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit t, input bit hv, input int ht, input bit hl,
                     input bit sh);
    @(negedge clk);
    frame_tick    = t;
    hit_valid     = hv;
    hit_type      = 3'(ht);
    hit_from_left = hl;
    btn_shield    = sh;
    model_step(t, hv, ht, hl, sh);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges and check outputs clear without a clock.
  task automatic reset_now();
    frame_tick = 0; hit_valid = 0; hit_type = 0; hit_from_left = 0; btn_shield = 0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive ticks until the model is idle again (bounded).
  task automatic settle();
    for (int i = 0; i < 200; i++) begin
      if (m_stun_left == 0 && m_inv_left == 0 && !m_pending) break;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Neutral hit from the left at 0%: +2/-1, 8 stun ticks, 30 invuln ticks.
    cyc(1'b0, 1'b1, 1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 45; i++) begin
      // contacts during hitstun (i==3) and invuln (i==20) must be discarded
      if (i == 3 || i == 20) cyc(1'b0, 1'b1, 2, 1'b0, 1'b0);
      else if (i % 4 == 1) idle_cyc();
      else tick();
    end
    settle();

    // Two contacts before a tick: only the first (side, from right) applies.
    // A contact in the consuming tick's clock is not captured.
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 3, 1'b1, 1'b0);
    settle();

    // Invalid types are never captured.
    cyc(1'b0, 1'b1, 0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 7, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5, 1'b1, 1'b0);
    tick();
    tick();

    // Reset in the middle of hitstun.
    cyc(1'b0, 1'b1, 3, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    reset_now();
    tick();

    // Shielded side hit at 0% (only meaningful when the shield is built in).
    cyc(1'b0, 1'b1, 2, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
    settle();

    // Long randomized run; damage climbs into saturation.
    for (int i = 0; i < 30000; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
          int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0));
    end

    // Saturated down hits from both sides: capped magnitude and stun.
    settle();
    cyc(1'b0, 1'b1, 4, 1'b1, 1'b0);
    tick();
    settle();
    cyc(1'b0, 1'b1, 4, 1'b0, 1'b0);
    tick();
    settle();
    check("pct_saturated", int'(damage_pct), PCT_MAX);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
